mem_req_ctrl: RTL and testbench

MEM_REQ_CTRL -- requirements
Module: mem_req_ctrl

---
 rtl/mem_req_ctrl.sv | 161 ++++++++++++++++
 tb/tb_mem_req_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: turns L2 miss/writeback requests into single-strobe block memory accesses.
// Optional read watchdog is compiled in when MEM_REQ_TIMEOUT_EN is defined.
module mem_req_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned BLOCK_SIZE = 16,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_write,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] req_wdata,
  output logic                             resp_valid,
  input  logic                             resp_ready,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] resp_rdata,
  output logic                             resp_err,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_wdata,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_rdata,
  output logic                             mem_read,
  output logic                             mem_write,
  input  logic                             mem_ready,
  input  logic                             mem_hit
);

  localparam int unsigned BLK_W = BLOCK_SIZE * DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] OFS_MASK = ADDR_WIDTH'(BLOCK_SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                r_state;
  logic                  r_write;
  logic                  r_req_ready;
  logic                  r_resp_valid;
  logic                  r_mem_read;
  logic                  r_mem_write;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [BLK_W-1:0]      r_mem_wdata;
  logic [BLK_W-1:0]      r_resp_rdata;

  logic [ADDR_WIDTH-1:0] w_aligned;
  logic                  w_hit;

  assign w_aligned = req_addr & ~OFS_MASK;
  assign w_hit     = mem_ready & mem_hit;

`ifdef MEM_REQ_TIMEOUT_EN
  localparam int unsigned   TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] r_tmo_cnt;
  logic          r_resp_err;

  assign resp_err = r_resp_err;
`else
  logic w_unused_timeout;

  assign w_unused_timeout = (TIMEOUT == 0);
  assign resp_err         = 1'b0;
`endif

  // Request FSM; every output is registered alongside the state it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_write      <= 1'b0;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_resp_rdata <= '0;
`ifdef MEM_REQ_TIMEOUT_EN
      r_tmo_cnt    <= '0;
      r_resp_err   <= 1'b0;
`endif
    end else begin
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_req_ready <= 1'b1;
          if (r_req_ready && req_valid) begin
            r_req_ready <= 1'b0;
            r_write     <= req_write;
            r_mem_addr  <= w_aligned;
            r_mem_wdata <= req_wdata;
            r_mem_read  <= ~req_write;
            r_mem_write <= req_write;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Writes are posted: no memory acknowledge is awaited.
          if (r_write) begin
            r_resp_valid <= 1'b1;
`ifdef MEM_REQ_TIMEOUT_EN
            r_resp_err   <= 1'b0;
`endif
            r_state      <= S_RESP;
          end else begin
`ifdef MEM_REQ_TIMEOUT_EN
            r_tmo_cnt    <= '0;
`endif
            r_state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_hit) begin
            r_resp_rdata <= mem_rdata;
            r_resp_valid <= 1'b1;
`ifdef MEM_REQ_TIMEOUT_EN
            r_resp_err   <= 1'b0;
`endif
            r_state      <= S_RESP;
          end
`ifdef MEM_REQ_TIMEOUT_EN
          else if (r_tmo_cnt == TMO_LAST) begin
            r_resp_rdata <= '0;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b1;
            r_state      <= S_RESP;
          end else begin
            r_tmo_cnt    <= r_tmo_cnt + TW'(1);
          end
`endif
        end
        S_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_resp_valid <= 1'b0;
          r_req_ready  <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_read   = r_mem_read;
  assign mem_write  = r_mem_write;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb_mem_req_ctrl: randomized bench for mem_req_ctrl against a transaction-level model
// with a reactive block memory (each word holds its own address).
module tb_mem_req_ctrl;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 32;
  localparam int unsigned BS    = 16;
  localparam int unsigned TMO   = 8;
  localparam int unsigned BLK_W = DW * BS;
`ifdef MEM_REQ_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  typedef logic [BLK_W-1:0] blk_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  blk_t          req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  blk_t          resp_rdata;
  logic          resp_err;
  logic [AW-1:0] mem_addr;
  blk_t          mem_wdata;
  blk_t          mem_rdata;
  logic          mem_read;
  logic          mem_write;
  logic          mem_ready;
  logic          mem_hit;

  int   n_tests = 0;
  int   n_fail  = 0;
  blk_t last_rdata;

  mem_req_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .BLOCK_SIZE(BS),
    .TIMEOUT   (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_ready (mem_ready),
    .mem_hit   (mem_hit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input blk_t got, input blk_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic blk_t addr_block(input logic [AW-1:0] base);
    blk_t b;
    for (int k = 0; k < BS; k++) b[k*DW +: DW] = DW'(base + AW'(k));
    return b;
  endfunction

  function automatic blk_t rand_blk();
    blk_t b;
    for (int k = 0; k < BS; k++) b[k*DW +: DW] = $urandom;
    return b;
  endfunction

  // One request through the model: dly = WAIT cycles before the memory hit.
  task automatic run_txn(input bit wr, input logic [AW-1:0] addr, input blk_t wdata,
                         input int dly, input int hold);
    logic [AW-1:0] exp_addr, strobe_addr;
    blk_t          exp_rdata, rd_blk, held, strobe_wdata;
    bit            exp_err;
    int            exp_lat, cyc, seen, j, n_rd, n_wr, n_both, strobe_cyc, busy_rdy, bad;

    exp_addr = (addr / AW'(BS)) * AW'(BS);
    rd_blk   = addr_block(exp_addr);
    if (wr) begin
      exp_lat = 2; exp_rdata = last_rdata; exp_err = 1'b0;
    end else if (TMO_ON && dly >= int'(TMO)) begin
      exp_lat = 2 + int'(TMO); exp_rdata = '0; exp_err = 1'b1;
    end else begin
      exp_lat = 3 + dly; exp_rdata = rd_blk; exp_err = 1'b0;
    end

    check("accept_ready", blk_t'(req_ready), blk_t'(1'b1));
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    tick();
    cyc = 1; seen = -1; n_rd = 0; n_wr = 0; n_both = 0; strobe_cyc = -1; busy_rdy = 0;
    strobe_addr = '0; strobe_wdata = '0;
    while (resp_valid !== 1'b1 && cyc < 80) begin
      if (mem_read === 1'b1) begin
        n_rd++; strobe_cyc = cyc; seen = cyc; strobe_addr = mem_addr;
      end
      if (mem_write === 1'b1) begin
        n_wr++; strobe_cyc = cyc; strobe_addr = mem_addr; strobe_wdata = mem_wdata;
      end
      if (mem_read === 1'b1 && mem_write === 1'b1) n_both++;
      if (req_ready !== 1'b0) busy_rdy++;
      req_valid  = 1'($urandom);
      req_write  = 1'($urandom);
      req_addr   = $urandom;
      resp_ready = 1'($urandom);
      mem_ready  = 1'b0; mem_hit = 1'b0; mem_rdata = rand_blk();
      if (seen >= 0 && cyc > seen) begin
        j = cyc - seen - 1;
        if (j < dly) begin
          if (j % 2 == 0) mem_ready = 1'b1;
          else            mem_hit   = 1'b1;
        end else if (j == dly) begin
          mem_ready = 1'b1; mem_hit = 1'b1; mem_rdata = rd_blk;
        end
      end
      tick();
      cyc++;
    end
    resp_ready = 1'b0; req_valid = 1'b0; mem_ready = 1'b0; mem_hit = 1'b0;

    check("latency",      blk_t'(cyc),        blk_t'(exp_lat));
    check("rd_pulses",    blk_t'(n_rd),       blk_t'(wr ? 0 : 1));
    check("wr_pulses",    blk_t'(n_wr),       blk_t'(wr ? 1 : 0));
    check("both_strobes", blk_t'(n_both),     blk_t'(0));
    check("strobe_cycle", blk_t'(strobe_cyc), blk_t'(1));
    check("strobe_addr",  blk_t'(strobe_addr), blk_t'(exp_addr));
    if (wr) check("strobe_wdata", strobe_wdata, wdata);
    check("busy_ready",   blk_t'(busy_rdy),   blk_t'(0));
    check("resp_rdata",   resp_rdata,         exp_rdata);
    check("resp_err",     blk_t'(resp_err),   blk_t'(exp_err));
    check("addr_held",    blk_t'(mem_addr),   blk_t'(exp_addr));

    held = resp_rdata;
    bad  = 0;
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1; req_addr = $urandom;
      tick();
      if (resp_valid !== 1'b1 || resp_rdata !== held || req_ready !== 1'b0 ||
          mem_read !== 1'b0 || mem_write !== 1'b0) bad++;
    end
    req_valid = 1'b0;
    if (hold > 0) check("resp_hold", blk_t'(bad), blk_t'(0));

    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("done_valid",  blk_t'(resp_valid),          blk_t'(1'b0));
    check("done_ready",  blk_t'(req_ready),           blk_t'(1'b1));
    check("done_strobe", blk_t'(mem_read | mem_write), blk_t'(1'b0));
    last_rdata = exp_rdata;
  endtask

  // Reset landing in WAIT drops the read; a late memory answer must be ignored.
  task automatic reset_in_wait();
    check("rw_accept", blk_t'(req_ready), blk_t'(1'b1));
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0047;
    tick();
    req_valid = 1'b0;
    check("rw_strobe", blk_t'(mem_read), blk_t'(1'b1));
    tick();
    #2 rst = 1'b1;
    #1;
    check("rw_valid",  blk_t'(resp_valid), blk_t'(1'b0));
    check("rw_read",   blk_t'(mem_read),   blk_t'(1'b0));
    check("rw_ready",  blk_t'(req_ready),  blk_t'(1'b0));
    check("rw_addr",   blk_t'(mem_addr),   blk_t'(0));
    mem_ready = 1'b1; mem_hit = 1'b1; mem_rdata = rand_blk();
    tick();
    check("rw_hold_ready", blk_t'(req_ready), blk_t'(1'b0));
    #2 rst = 1'b0;
    tick();
    check("rw_ready_after", blk_t'(req_ready),  blk_t'(1'b1));
    check("rw_late_ignored", blk_t'(resp_valid), blk_t'(1'b0));
    check("rw_no_strobe", blk_t'(mem_read | mem_write), blk_t'(1'b0));
    mem_ready = 1'b0; mem_hit = 1'b0;
    tick();
    check("rw_idle_valid", blk_t'(resp_valid), blk_t'(1'b0));
    check("rw_rdata_clr",  resp_rdata,         blk_t'(0));
    last_rdata = '0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b0; mem_rdata = '0; mem_ready = 1'b0; mem_hit = 1'b0;
    last_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready",  blk_t'(req_ready),  blk_t'(1'b0));
    check("rst_resp_valid", blk_t'(resp_valid), blk_t'(1'b0));
    check("rst_resp_err",   blk_t'(resp_err),   blk_t'(1'b0));
    check("rst_resp_rdata", resp_rdata,         blk_t'(0));
    check("rst_strobes",    blk_t'({mem_read, mem_write}), blk_t'(0));
    check("rst_mem_addr",   blk_t'(mem_addr),   blk_t'(0));
    check("rst_mem_wdata",  mem_wdata,          blk_t'(0));
    #2 rst = 1'b0;
    tick();
    check("ready_after_rst", blk_t'(req_ready), blk_t'(1'b1));

    run_txn(1'b0, 32'h0000_0025, rand_blk(), 1, 0);
    check("read_word0",  blk_t'(last_rdata[31:0]),    blk_t'(32'h20));
    check("read_word15", blk_t'(last_rdata[511:480]), blk_t'(32'h2F));
    run_txn(1'b1, 32'h0000_0013, {BS{32'h0000_00A5}}, 0, 0);
    run_txn(1'b0, 32'h0001_0F3C, rand_blk(), 2, 5);
    run_txn(1'b0, 32'h0000_1234, rand_blk(), 4, 0);
    reset_in_wait();
    if (TMO_ON) run_txn(1'b0, 32'h0000_0500, rand_blk(), 1000, 2);

    for (int t = 0; t < 40; t++)
      run_txn(1'($urandom), $urandom, rand_blk(), int'($urandom_range(0, 6)),
              int'($urandom_range(0, 3)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
